branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/br_pkg.sv | 20 ++
 rtl/branch_stats.sv | 24 ++
 rtl/branch_resolver.sv | 83 ++++++++
 tb/tb_branch_resolver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types for the EX-stage branch resolver: default address width,
// slot-state enum and the record held by the single EX slot.
package br_pkg;

  localparam int BR_ADDR_W = 32;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } slot_state_e;

  // Slot fields are sized by the package default; the top casts to and from
  // its own ADDR_W, so widths up to BR_ADDR_W are supported.
  typedef struct packed {
    logic                 pred;
    logic [BR_ADDR_W-1:0] pc4;
    logic [BR_ADDR_W-1:0] target;
  } br_slot_t;

endpackage

// File: rtl/branch_stats.sv
// Saturating resolved-branch and misprediction counters for the branch
// resolver; only instantiated when BRANCH_STATS_EN is defined.
module branch_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             branch_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_o  <= '0;
      mis_cnt_o <= '0;
    end else begin
      if (branch_i && (br_cnt_o != '1)) br_cnt_o <= br_cnt_o + 1'b1;
      if (flush_i && (mis_cnt_o != '1)) mis_cnt_o <= mis_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage conditional-branch resolver: one-entry slot, misprediction flush
// and redirect. Optional statistics counters under macro BRANCH_STATS_EN.
module branch_resolver
  import br_pkg::*;
#(
  parameter int ADDR_W = BR_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              id_branch_i,
  input  logic              id_predict_i,
  input  logic [ADDR_W-1:0] id_pc4_i,
  input  logic [ADDR_W-1:0] id_target_i,
  input  logic              ex_zero_i,
  output logic              Branch_o,
  output logic              result_o,
  output logic              flush_o,
`ifdef BRANCH_STATS_EN
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  br_cnt_o,
  output logic [CNT_W-1:0]  mis_cnt_o
`else
  output logic [ADDR_W-1:0] redirect_pc_o
`endif
);

  slot_state_e state_q, state_d;
  br_slot_t    slot_q, slot_d;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset so a mid-cycle rst_n drop empties the slot without a clock edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // A wrong-path ID branch (flush this cycle) or a held ID stage yields a bubble.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = EMPTY;
    slot_d  = slot_q;
    if (id_branch_i && !stall_i && !flush_o) begin
      state_d       = PENDING;
      slot_d.pred   = id_predict_i;
      slot_d.pc4    = BR_ADDR_W'(id_pc4_i);
      slot_d.target = BR_ADDR_W'(id_target_i);
    end
  end

  always_comb begin
    Branch_o      = 1'b0;
    result_o      = 1'b0;
    flush_o       = 1'b0;
    redirect_pc_o = '0;
    if (state_q == PENDING) begin
      Branch_o      = 1'b1;
      result_o      = ex_zero_i;
      flush_o       = (slot_q.pred != ex_zero_i);
      redirect_pc_o = ex_zero_i ? ADDR_W'(slot_q.target) : ADDR_W'(slot_q.pc4);
    end
  end

`ifdef BRANCH_STATS_EN
  branch_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .branch_i  (Branch_o),
    .flush_i   (flush_o),
    .br_cnt_o  (br_cnt_o),
    .mis_cnt_o (mis_cnt_o)
  );
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; the statistics section
// is compiled only when BRANCH_STATS_EN is defined.
module tb_branch_resolver;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic              stall_i, id_branch_i, id_predict_i, ex_zero_i;
  logic [ADDR_W-1:0] id_pc4_i, id_target_i;
  logic              Branch_o, result_o, flush_o;
  logic [ADDR_W-1:0] redirect_pc_o;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0]  br_cnt_o, mis_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  branch_resolver #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .id_branch_i   (id_branch_i),
    .id_predict_i  (id_predict_i),
    .id_pc4_i      (id_pc4_i),
    .id_target_i   (id_target_i),
    .ex_zero_i     (ex_zero_i),
    .Branch_o      (Branch_o),
    .result_o      (result_o),
    .flush_o       (flush_o),
`ifdef BRANCH_STATS_EN
    .redirect_pc_o (redirect_pc_o),
    .br_cnt_o      (br_cnt_o),
    .mis_cnt_o     (mis_cnt_o)
`else
    .redirect_pc_o (redirect_pc_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // after a further settle delay, well before the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic br, input logic res,
                            input logic fl, input logic [ADDR_W-1:0] pc);
    #1;
    check({tag, ".Branch_o"}, 64'(Branch_o), 64'(br));
    check({tag, ".result_o"}, 64'(result_o), 64'(res));
    check({tag, ".flush_o"},  64'(flush_o),  64'(fl));
    check({tag, ".redirect"}, 64'(redirect_pc_o), 64'(pc));
  endtask

  task automatic id_drive(input logic br, input logic pred,
                          input logic [ADDR_W-1:0] pc4, input logic [ADDR_W-1:0] tgt);
    id_branch_i  = br;
    id_predict_i = pred;
    id_pc4_i     = pc4;
    id_target_i  = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0;
    ex_zero_i = 1'b1;
    id_drive(1'b1, 1'b1, 32'h4, 32'h8);
    #3;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    ex_zero_i = 1'b0;
    id_drive(1'b0, 1'b0, 32'h0, 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // Correctly predicted taken branch resolves one cycle after capture.
    id_drive(1'b1, 1'b1, 32'h10, 32'h40);
    tick();
    id_drive(1'b0, 1'b0, 32'h0, 32'h0);
    ex_zero_i = 1'b1;
    check_outs("taken_ok", 1'b1, 1'b1, 1'b0, 32'h40);
    tick();
    check_outs("empty_after", 1'b0, 1'b0, 1'b0, 32'h0);

    // Predicted taken, actually not taken: flush to pc4; younger ID branch dropped.
    id_drive(1'b1, 1'b1, 32'h1C, 32'h80);
    tick();
    ex_zero_i = 1'b0;
    id_drive(1'b1, 1'b0, 32'h99, 32'hA0);
    check_outs("mispred", 1'b1, 1'b0, 1'b1, 32'h1C);
    tick();
    id_drive(1'b0, 1'b0, 32'h0, 32'h0);
    check_outs("wrongpath_dropped", 1'b0, 1'b0, 1'b0, 32'h0);

    // ID branch held by two stall cycles, then released: one pulse only.
    stall_i = 1'b1;
    id_drive(1'b1, 1'b0, 32'h20, 32'h60);
    tick();
    check_outs("stall1", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_outs("stall2", 1'b0, 1'b0, 1'b0, 32'h0);
    stall_i = 1'b0;
    tick();
    id_drive(1'b0, 1'b0, 32'h0, 32'h0);
    check_outs("stall_release", 1'b1, 1'b0, 1'b0, 32'h20);
    tick();
    check_outs("stall_once", 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset while PENDING discards the branch.
    id_drive(1'b1, 1'b0, 32'h24, 32'h30);
    tick();
    id_drive(1'b0, 1'b0, 32'h0, 32'h0);
    ex_zero_i = 1'b1;
    check_outs("pre_reset", 1'b1, 1'b1, 1'b1, 32'h30);
    #1 rst_n = 1'b0;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check_outs("post_reset1", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_outs("post_reset2", 1'b0, 1'b0, 1'b0, 32'h0);

    // Back-to-back correctly predicted branches: two consecutive pulses.
    id_drive(1'b1, 1'b1, 32'h54, 32'h100);
    tick();
    id_drive(1'b1, 1'b0, 32'h58, 32'h200);
    ex_zero_i = 1'b1;
    check_outs("b2b_first", 1'b1, 1'b1, 1'b0, 32'h100);
    tick();
    id_drive(1'b0, 1'b0, 32'h0, 32'h0);
    ex_zero_i = 1'b0;
    check_outs("b2b_second", 1'b1, 1'b0, 1'b0, 32'h58);
    tick();
    check_outs("b2b_done", 1'b0, 1'b0, 1'b0, 32'h0);

`ifdef BRANCH_STATS_EN
    // Counters clear on reset and saturate at all-ones after 20 mispredictions.
    #1 rst_n = 1'b0;
    #1;
    check("cnt_reset_br",  64'(br_cnt_o),  64'h0);
    check("cnt_reset_mis", 64'(mis_cnt_o), 64'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      id_drive(1'b1, 1'b1, 32'h1000 + 32'(i * 4), 32'h2000);
      tick();
      id_drive(1'b0, 1'b0, 32'h0, 32'h0);
      ex_zero_i = 1'b0;
      if (i == 2) begin
        tick();
        check("cnt_three_br",  64'(br_cnt_o),  64'h3);
        check("cnt_three_mis", 64'(mis_cnt_o), 64'h3);
      end
    end
    tick();
    check("cnt_sat_br",  64'(br_cnt_o),  64'hF);
    check("cnt_sat_mis", 64'(mis_cnt_o), 64'hF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
